// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline constants, encodings and FSM state type
package pipe_pkg;
  localparam int CTRL_REGW  = 4;
  localparam int CTRL_WBSEL = 2;
  localparam int CTRL_MRD   = 1;
  localparam int CTRL_MWR   = 0;
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [31:0] ALIGN_MASK = 32'h0000_0003;
  typedef enum logic {IDLE, BUSY} state_t;
endpackage

// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register; stall inserts a bubble and holds tag/data
module mem_wb_reg (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_stall,
  input  logic        i_we,
  input  logic [31:0] i_rd,
  input  logic [31:0] i_data,
  output logic        o_we,
  output logic [31:0] o_rd,
  output logic [31:0] o_data
);
  logic        r_we;
  logic [31:0] r_rd;
  logic [31:0] r_data;

  // load on free cycles, bubble the write enable while stalled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we   <= 1'b0;
      r_rd   <= '0;
      r_data <= '0;
    end else if (i_stall) begin
      r_we   <= 1'b0;
    end else begin
      r_we   <= i_we;
      r_rd   <= i_rd;
      r_data <= i_data;
    end
  end

  assign o_we   = r_we;
  assign o_rd   = r_rd;
  assign o_data = r_data;
endmodule

// File: rtl/mem_access.sv
// mem_access: MEM stage - word load/store over req/ack bus, stall, write-back select
module mem_access
  import pipe_pkg::*;
#(
  parameter int WAIT_LIMIT = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  ctrl_mem,
  input  logic [31:0] rd_mem,
  input  logic [31:0] pc4_mem,
  input  logic [31:0] alu_result,
  input  logic [31:0] write_data1,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_we,
  output logic [31:0] rd_wb,
  output logic [31:0] wb_data,
  output logic        mem_err
);
  state_t      r_state, w_nstate;
  logic [7:0]  r_cnt, w_ncnt;
  logic        r_err;
  logic        w_mrd, w_mwr, w_op, w_aligned, w_acc, w_misalign, w_abort;
  logic [1:0]  w_wbsel;
  logic [31:0] w_ld, w_wb_data;

  assign w_mrd      = ctrl_mem[CTRL_MRD];
  assign w_mwr      = ctrl_mem[CTRL_MWR];
  assign w_wbsel    = ctrl_mem[CTRL_WBSEL+1:CTRL_WBSEL];
  assign w_op       = w_mrd | w_mwr;
  assign w_aligned  = (alu_result & ALIGN_MASK) == 32'd0;
  assign w_acc      = w_op & w_aligned;
  assign w_misalign = w_op & ~w_aligned;
  assign w_abort    = (r_state == BUSY) & w_acc & ~dmem_ack & (r_cnt == 8'(WAIT_LIMIT));

  // bus is driven straight from the EX/MEM inputs; reset forces req/stall low
  assign dmem_req   = w_acc & reset_n;
  assign dmem_we    = w_mwr;
  assign dmem_addr  = alu_result;
  assign dmem_wdata = write_data1;
  assign stall      = w_acc & ~dmem_ack & ~w_abort & reset_n;

  // load data is only real on an acked aligned load; stores, misalign and timeout read as 0
  always_comb begin
    w_ld      = (w_acc & ~w_mwr & dmem_ack) ? dmem_rdata : 32'd0;
    w_wb_data = (w_wbsel == WB_MEM) ? w_ld : (w_wbsel == WB_PC4) ? pc4_mem : alu_result;
  end

  // next-state and wait counter: enter BUSY on an unacked request, leave on ack or timeout
  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    if (r_state == IDLE) begin
      if (w_acc & ~dmem_ack) begin
        w_nstate = BUSY;
        w_ncnt   = 8'd1;
      end
    end else if (~w_acc | dmem_ack | w_abort) begin
      w_nstate = IDLE;
      w_ncnt   = 8'd0;
    end else begin
      w_ncnt   = r_cnt + 8'd1;
    end
  end

  // state, counter and sticky error flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
      r_err   <= r_err | w_misalign | w_abort;
    end
  end

  assign mem_err = r_err;

  mem_wb_reg u_mem_wb_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .i_stall (stall),
    .i_we    (ctrl_mem[CTRL_REGW]),
    .i_rd    (rd_mem),
    .i_data  (w_wb_data),
    .o_we    (wb_we),
    .o_rd    (rd_wb),
    .o_data  (wb_data)
  );
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed self-checking bench for mem_access
module tb_mem_access;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  ctrl_mem;
  logic [31:0] rd_mem, pc4_mem, alu_result, write_data1, dmem_rdata;
  logic        dmem_ack;
  logic        stall, dmem_req, dmem_we, wb_we, mem_err;
  logic [31:0] dmem_addr, dmem_wdata, rd_wb, wb_data;
  int checks = 0;
  int failures = 0;
  int cnt;

  always #5 clk = ~clk;

  mem_access #(.WAIT_LIMIT(15)) dut (
    .clk(clk), .reset_n(reset_n), .ctrl_mem(ctrl_mem), .rd_mem(rd_mem),
    .pc4_mem(pc4_mem), .alu_result(alu_result), .write_data1(write_data1),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_we(wb_we), .rd_wb(rd_wb), .wb_data(wb_data), .mem_err(mem_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] c, input logic [31:0] a, input logic [31:0] rd,
                       input logic ack, input logic [31:0] rdat);
    ctrl_mem = c; alu_result = a; rd_mem = rd; dmem_ack = ack; dmem_rdata = rdat;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(5'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    pc4_mem = 32'd0; write_data1 = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_wb_we", 32'(wb_we), 32'd0);
    chk("rst_rd_wb", rd_wb, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_mem_err", 32'(mem_err), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    reset_n = 1'b1;
    // ALU pass-through
    drive(5'b1_00_00, 32'h1234_5678, 32'd5, 1'b0, 32'd0);
    #1;
    chk("alu_stall", 32'(stall), 32'd0);
    chk("alu_req", 32'(dmem_req), 32'd0);
    @(negedge clk);
    chk("alu_wb_we", 32'(wb_we), 32'd1);
    chk("alu_rd_wb", rd_wb, 32'd5);
    chk("alu_wb_data", wb_data, 32'h1234_5678);
    // zero-wait load
    drive(5'b1_01_10, 32'h100, 32'd7, 1'b1, 32'hDEAD_BEEF);
    #1;
    chk("zld_req", 32'(dmem_req), 32'd1);
    chk("zld_addr", dmem_addr, 32'h100);
    chk("zld_we", 32'(dmem_we), 32'd0);
    chk("zld_stall", 32'(stall), 32'd0);
    @(negedge clk);
    chk("zld_wb_data", wb_data, 32'hDEAD_BEEF);
    chk("zld_rd_wb", rd_wb, 32'd7);
    // 3-wait store
    write_data1 = 32'hA5A5_A5A5;
    drive(5'b0_00_01, 32'h40, 32'd9, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("st_stall", 32'(stall), 32'd1);
      chk("st_we", 32'(dmem_we), 32'd1);
      chk("st_wdata", dmem_wdata, 32'hA5A5_A5A5);
      @(negedge clk);
      chk("st_wb_we", 32'(wb_we), 32'd0);
      chk("st_rd_hold", rd_wb, 32'd7);
    end
    dmem_ack = 1'b1;
    #1;
    chk("st_ack_stall", 32'(stall), 32'd0);
    @(negedge clk);
    chk("st_done_wb_we", 32'(wb_we), 32'd0);
    chk("st_done_rd_wb", rd_wb, 32'd9);
    chk("st_done_wb_data", wb_data, 32'h40);
    chk("st_mem_err", 32'(mem_err), 32'd0);
    // misaligned load
    drive(5'b1_01_10, 32'h102, 32'd11, 1'b0, 32'hFFFF_FFFF);
    #1;
    chk("mis_req", 32'(dmem_req), 32'd0);
    chk("mis_stall", 32'(stall), 32'd0);
    chk("mis_err_before", 32'(mem_err), 32'd0);
    @(negedge clk);
    chk("mis_err", 32'(mem_err), 32'd1);
    chk("mis_wb_data", wb_data, 32'd0);
    chk("mis_wb_we", 32'(wb_we), 32'd1);
    // late ack in IDLE without request is ignored
    drive(5'b0_00_00, 32'h8, 32'd0, 1'b1, 32'd0);
    #1;
    chk("late_ack_req", 32'(dmem_req), 32'd0);
    chk("late_ack_stall", 32'(stall), 32'd0);
    @(negedge clk);
    // reset pulse clears sticky error
    reset_n = 1'b0;
    #1;
    chk("err_cleared", 32'(mem_err), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    // timeout load
    drive(5'b1_01_10, 32'h200, 32'd3, 1'b0, 32'h5555_5555);
    cnt = 0;
    #1;
    while (stall && cnt < 40) begin
      cnt++;
      @(negedge clk);
      #1;
    end
    chk("to_stall_cycles", 32'(cnt), 32'd15);
    chk("to_abort_stall", 32'(stall), 32'd0);
    @(negedge clk);
    chk("to_mem_err", 32'(mem_err), 32'd1);
    chk("to_wb_data", wb_data, 32'd0);
    chk("to_wb_we", 32'(wb_we), 32'd1);
    chk("to_rd_wb", rd_wb, 32'd3);
    // FSM back in IDLE: a fresh unacked load must stall, not abort
    drive(5'b1_01_10, 32'h204, 32'd4, 1'b0, 32'd0);
    #1;
    chk("to_idle_stall", 32'(stall), 32'd1);
    @(negedge clk);
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_0001;
    @(negedge clk);
    chk("post_to_ld", wb_data, 32'hCAFE_0001);
    // JAL write-back
    pc4_mem = 32'h2004;
    drive(5'b1_10_00, 32'h3333, 32'd1, 1'b0, 32'd0);
    @(negedge clk);
    chk("jal_wb_data", wb_data, 32'h2004);
    chk("jal_rd_wb", rd_wb, 32'd1);
    // reset mid-BUSY
    drive(5'b1_01_10, 32'h300, 32'd2, 1'b0, 32'd0);
    @(negedge clk);
    #1;
    chk("rb_stall", 32'(stall), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rb_req", 32'(dmem_req), 32'd0);
    chk("rb_stall0", 32'(stall), 32'd0);
    chk("rb_wb_we", 32'(wb_we), 32'd0);
    chk("rb_rd_wb", rd_wb, 32'd0);
    chk("rb_wb_data", wb_data, 32'd0);
    chk("rb_mem_err", 32'(mem_err), 32'd0);
    drive(5'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rb_after_wb_we", 32'(wb_we), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
